// File: rtl/e203_soc_pad_top.sv
`default_nettype none
// e203_soc_pad_top: pad-level shell of the E203 SoC -- reset/strap handling,
// input synchronisers, RTC tick, always-on PMU and pad pass-through muxing.
module e203_soc_pad_top #(
  parameter int          GPIO_W    = 32,
  parameter int          SYNC_STG  = 2,
  parameter logic [31:0] ROM_BOOT  = 32'h0000_1000,
  parameter logic [31:0] ITCM_BOOT = 32'h8000_0000
) (
  input  logic              hfclk,
  input  logic              rst_n,
  input  logic              lfextclk,
  output logic              hfxoscen,
  output logic              lfxoscen,
  input  logic              io_pads_jtag_TCK_i_ival,
  input  logic              io_pads_jtag_TMS_i_ival,
  input  logic              io_pads_jtag_TDI_i_ival,
  output logic              io_pads_jtag_TDO_o_oval,
  output logic              io_pads_jtag_TDO_o_oe,
  input  logic [GPIO_W-1:0] io_pads_gpioA_i_ival,
  output logic [GPIO_W-1:0] io_pads_gpioA_o_oval,
  output logic [GPIO_W-1:0] io_pads_gpioA_o_oe,
  input  logic [GPIO_W-1:0] io_pads_gpioB_i_ival,
  output logic [GPIO_W-1:0] io_pads_gpioB_o_oval,
  output logic [GPIO_W-1:0] io_pads_gpioB_o_oe,
  output logic              io_pads_qspi0_sck_o_oval,
  output logic              io_pads_qspi0_cs_0_o_oval,
  input  logic              io_pads_qspi0_dq_0_i_ival,
  output logic              io_pads_qspi0_dq_0_o_oval,
  output logic              io_pads_qspi0_dq_0_o_oe,
  input  logic              io_pads_qspi0_dq_1_i_ival,
  output logic              io_pads_qspi0_dq_1_o_oval,
  output logic              io_pads_qspi0_dq_1_o_oe,
  input  logic              io_pads_qspi0_dq_2_i_ival,
  output logic              io_pads_qspi0_dq_2_o_oval,
  output logic              io_pads_qspi0_dq_2_o_oe,
  input  logic              io_pads_qspi0_dq_3_i_ival,
  output logic              io_pads_qspi0_dq_3_o_oval,
  output logic              io_pads_qspi0_dq_3_o_oe,
  input  logic              io_pads_aon_pmu_dwakeup_n_i_ival,
  output logic              io_pads_aon_pmu_vddpaden_o_oval,
  output logic              io_pads_aon_pmu_padrst_o_oval,
  input  logic              io_pads_bootrom_n_i_ival,
  input  logic              io_pads_dbgmode0_n_i_ival,
  input  logic              io_pads_dbgmode1_n_i_ival,
  input  logic              io_pads_dbgmode2_n_i_ival,
  output logic              core_rst_n,
  output logic [31:0]       core_boot_addr,
  output logic [2:0]        core_dbg_mode,
  output logic              core_rtc_tick,
  output logic              core_jtag_tck,
  output logic              core_jtag_tms,
  output logic              core_jtag_tdi,
  input  logic              core_jtag_tdo,
  input  logic              core_jtag_tdo_oe,
  output logic [GPIO_W-1:0] core_gpioA_in,
  input  logic [GPIO_W-1:0] core_gpioA_out,
  input  logic [GPIO_W-1:0] core_gpioA_oe,
  output logic [GPIO_W-1:0] core_gpioB_in,
  input  logic [GPIO_W-1:0] core_gpioB_out,
  input  logic [GPIO_W-1:0] core_gpioB_oe,
  input  logic              core_qspi_sck,
  input  logic              core_qspi_cs,
  input  logic [3:0]        core_qspi_dq_out,
  input  logic [3:0]        core_qspi_dq_oe,
  output logic [3:0]        core_qspi_dq_in,
  input  logic              core_sleep_req
);

  typedef enum logic [1:0] {
    PMU_RUN   = 2'd0,
    PMU_SLEEP = 2'd1,
    PMU_WAKE  = 2'd2
  } pmu_state_e;

  localparam int SW = 2 * GPIO_W + 6;

  pmu_state_e                  pmu_q, pmu_d;
  logic [SYNC_STG-1:0]         rst_sync_q;
  logic                        rst_clr;
  logic                        rst_rise;
  logic                        strap_done_q;
  logic [31:0]                 boot_addr_q;
  logic [2:0]                  dbg_mode_q;
  logic [SYNC_STG-1:0][SW-1:0] in_sync_q;
  logic [SW-1:0]               sync_in;
  logic [SW-1:0]               sync_out;
  logic                        lf_sync;
  logic                        lf_dly_q;
  logic                        wake_req;

  // Wake is synchronised active-high so that the reset value 0 means "no wake".
  assign sync_in = {~io_pads_aon_pmu_dwakeup_n_i_ival, lfextclk,
                    io_pads_qspi0_dq_3_i_ival, io_pads_qspi0_dq_2_i_ival,
                    io_pads_qspi0_dq_1_i_ival, io_pads_qspi0_dq_0_i_ival,
                    io_pads_gpioB_i_ival, io_pads_gpioA_i_ival};

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      in_sync_q <= '0;
      lf_dly_q  <= 1'b0;
    end else begin
      in_sync_q <= {in_sync_q[SYNC_STG-2:0], sync_in};
      lf_dly_q  <= lf_sync;
    end
  end

  assign sync_out        = in_sync_q[SYNC_STG-1];
  assign core_gpioA_in   = sync_out[GPIO_W-1:0];
  assign core_gpioB_in   = sync_out[2*GPIO_W-1:GPIO_W];
  assign core_qspi_dq_in = sync_out[2*GPIO_W+3:2*GPIO_W];
  assign lf_sync         = sync_out[2*GPIO_W+4];
  assign wake_req        = sync_out[2*GPIO_W+5];
  assign core_rtc_tick   = lf_sync & ~lf_dly_q;

  // The reset synchroniser is held clear while sleeping (and on the entry edge),
  // so leaving SLEEP replays a full SYNC_STG-cycle release.
  assign rst_clr  = (pmu_q == PMU_SLEEP) || (pmu_d == PMU_SLEEP);
  assign rst_rise = rst_sync_q[SYNC_STG-2] & ~rst_sync_q[SYNC_STG-1] & ~rst_clr;

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else if (rst_clr) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[SYNC_STG-2:0], 1'b1};
    end
  end

  assign core_rst_n = rst_sync_q[SYNC_STG-1];

  // Straps are captured once per pad reset, on the first core reset release.
  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      strap_done_q <= 1'b0;
      boot_addr_q  <= ROM_BOOT;
      dbg_mode_q   <= 3'b000;
    end else if (rst_rise && !strap_done_q) begin
      strap_done_q <= 1'b1;
      boot_addr_q  <= io_pads_bootrom_n_i_ival ? ITCM_BOOT : ROM_BOOT;
      dbg_mode_q   <= ~{io_pads_dbgmode2_n_i_ival, io_pads_dbgmode1_n_i_ival,
                        io_pads_dbgmode0_n_i_ival};
    end
  end

  assign core_boot_addr = boot_addr_q;
  assign core_dbg_mode  = dbg_mode_q;

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      pmu_q <= PMU_RUN;
    end else begin
      pmu_q <= pmu_d;
    end
  end

  always_comb begin
    pmu_d                           = pmu_q;
    io_pads_aon_pmu_vddpaden_o_oval = 1'b1;
    io_pads_aon_pmu_padrst_o_oval   = 1'b1;
    hfxoscen                        = 1'b1;
    case (pmu_q)
      PMU_RUN: begin
        io_pads_aon_pmu_padrst_o_oval = ~core_rst_n;
        if (core_sleep_req) pmu_d = PMU_SLEEP;
      end
      PMU_SLEEP: begin
        io_pads_aon_pmu_vddpaden_o_oval = 1'b0;
        hfxoscen                        = 1'b0;
        if (wake_req) pmu_d = PMU_WAKE;
      end
      PMU_WAKE: begin
        if (rst_sync_q[SYNC_STG-2]) pmu_d = PMU_RUN;
      end
      default: pmu_d = PMU_RUN;
    endcase
  end

  assign lfxoscen = 1'b1;

  assign core_jtag_tck           = io_pads_jtag_TCK_i_ival;
  assign core_jtag_tms           = io_pads_jtag_TMS_i_ival;
  assign core_jtag_tdi           = io_pads_jtag_TDI_i_ival;
  assign io_pads_jtag_TDO_o_oval = core_jtag_tdo;
  assign io_pads_jtag_TDO_o_oe   = core_jtag_tdo_oe;

  assign io_pads_gpioA_o_oval = core_gpioA_out;
  assign io_pads_gpioA_o_oe   = core_gpioA_oe;
  assign io_pads_gpioB_o_oval = core_gpioB_out;
  assign io_pads_gpioB_o_oe   = core_gpioB_oe;

  assign io_pads_qspi0_sck_o_oval  = core_qspi_sck;
  assign io_pads_qspi0_cs_0_o_oval = core_qspi_cs;
  assign io_pads_qspi0_dq_0_o_oval = core_qspi_dq_out[0];
  assign io_pads_qspi0_dq_1_o_oval = core_qspi_dq_out[1];
  assign io_pads_qspi0_dq_2_o_oval = core_qspi_dq_out[2];
  assign io_pads_qspi0_dq_3_o_oval = core_qspi_dq_out[3];
  assign io_pads_qspi0_dq_0_o_oe   = core_qspi_dq_oe[0];
  assign io_pads_qspi0_dq_1_o_oe   = core_qspi_dq_oe[1];
  assign io_pads_qspi0_dq_2_o_oe   = core_qspi_dq_oe[2];
  assign io_pads_qspi0_dq_3_o_oe   = core_qspi_dq_oe[3];

endmodule
`default_nettype wire

// File: tb/tb_e203_soc_pad_top.sv
`default_nettype none
// Self-checking bench for e203_soc_pad_top: randomized stimulus against a
// behavioural model of reset, straps, synchronisers, RTC and PMU.
module tb_e203_soc_pad_top;

  localparam int          W    = 32;
  localparam logic [31:0] ROMB = 32'h0000_1000;
  localparam logic [31:0] ITCB = 32'h8000_0000;

  logic hfclk = 1'b0, rst_n = 1'b0, lfextclk = 1'b0;
  logic hfxoscen, lfxoscen;
  logic tck = 1'b0, tms = 1'b0, tdi = 1'b0, tdo_oval, tdo_oe;
  logic [W-1:0] gpa_i = '0, gpa_oval, gpa_oe, gpb_i = '0, gpb_oval, gpb_oe;
  logic sck_oval, cs_oval;
  logic [3:0] dq_i = '0;
  logic dq0_ov, dq0_oe, dq1_ov, dq1_oe, dq2_ov, dq2_oe, dq3_ov, dq3_oe;
  logic dwakeup_n = 1'b1, vddpaden, padrst;
  logic bootrom_n = 1'b0;
  logic [2:0] dbg_n = 3'b111;
  logic core_rst_n, core_rtc_tick;
  logic [31:0] core_boot_addr;
  logic [2:0] core_dbg_mode;
  logic c_tck, c_tms, c_tdi, c_tdo = 1'b0, c_tdo_oe = 1'b0;
  logic [W-1:0] c_gpa_in, c_gpa_out = '0, c_gpa_oe = '0, c_gpb_in, c_gpb_out = '0, c_gpb_oe = '0;
  logic c_sck = 1'b0, c_cs = 1'b0;
  logic [3:0] c_dq_out = '0, c_dq_oe = '0, c_dq_in;
  logic c_sleep_req = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int tick_cnt = 0;
  bit tick_en = 1'b0;

  e203_soc_pad_top dut (
    .hfclk(hfclk), .rst_n(rst_n), .lfextclk(lfextclk),
    .hfxoscen(hfxoscen), .lfxoscen(lfxoscen),
    .io_pads_jtag_TCK_i_ival(tck), .io_pads_jtag_TMS_i_ival(tms), .io_pads_jtag_TDI_i_ival(tdi),
    .io_pads_jtag_TDO_o_oval(tdo_oval), .io_pads_jtag_TDO_o_oe(tdo_oe),
    .io_pads_gpioA_i_ival(gpa_i), .io_pads_gpioA_o_oval(gpa_oval), .io_pads_gpioA_o_oe(gpa_oe),
    .io_pads_gpioB_i_ival(gpb_i), .io_pads_gpioB_o_oval(gpb_oval), .io_pads_gpioB_o_oe(gpb_oe),
    .io_pads_qspi0_sck_o_oval(sck_oval), .io_pads_qspi0_cs_0_o_oval(cs_oval),
    .io_pads_qspi0_dq_0_i_ival(dq_i[0]), .io_pads_qspi0_dq_0_o_oval(dq0_ov), .io_pads_qspi0_dq_0_o_oe(dq0_oe),
    .io_pads_qspi0_dq_1_i_ival(dq_i[1]), .io_pads_qspi0_dq_1_o_oval(dq1_ov), .io_pads_qspi0_dq_1_o_oe(dq1_oe),
    .io_pads_qspi0_dq_2_i_ival(dq_i[2]), .io_pads_qspi0_dq_2_o_oval(dq2_ov), .io_pads_qspi0_dq_2_o_oe(dq2_oe),
    .io_pads_qspi0_dq_3_i_ival(dq_i[3]), .io_pads_qspi0_dq_3_o_oval(dq3_ov), .io_pads_qspi0_dq_3_o_oe(dq3_oe),
    .io_pads_aon_pmu_dwakeup_n_i_ival(dwakeup_n),
    .io_pads_aon_pmu_vddpaden_o_oval(vddpaden), .io_pads_aon_pmu_padrst_o_oval(padrst),
    .io_pads_bootrom_n_i_ival(bootrom_n),
    .io_pads_dbgmode0_n_i_ival(dbg_n[0]), .io_pads_dbgmode1_n_i_ival(dbg_n[1]),
    .io_pads_dbgmode2_n_i_ival(dbg_n[2]),
    .core_rst_n(core_rst_n), .core_boot_addr(core_boot_addr), .core_dbg_mode(core_dbg_mode),
    .core_rtc_tick(core_rtc_tick),
    .core_jtag_tck(c_tck), .core_jtag_tms(c_tms), .core_jtag_tdi(c_tdi),
    .core_jtag_tdo(c_tdo), .core_jtag_tdo_oe(c_tdo_oe),
    .core_gpioA_in(c_gpa_in), .core_gpioA_out(c_gpa_out), .core_gpioA_oe(c_gpa_oe),
    .core_gpioB_in(c_gpb_in), .core_gpioB_out(c_gpb_out), .core_gpioB_oe(c_gpb_oe),
    .core_qspi_sck(c_sck), .core_qspi_cs(c_cs), .core_qspi_dq_out(c_dq_out),
    .core_qspi_dq_oe(c_dq_oe), .core_qspi_dq_in(c_dq_in),
    .core_sleep_req(c_sleep_req)
  );

  always #2 hfclk = ~hfclk;

  always @(negedge hfclk) if (tick_en && core_rtc_tick === 1'b1) tick_cnt++;

  task automatic step();
    @(posedge hfclk);
    #1;
  endtask

  // {core_rst_n, padrst, vddpaden, hfxoscen, lfxoscen, tick}
  function automatic logic [5:0] pmu_vec();
    return {core_rst_n, padrst, vddpaden, hfxoscen, lfxoscen, core_rtc_tick};
  endfunction

  task automatic reset_release(input logic brn, input logic [2:0] dn);
    bootrom_n = brn;
    dbg_n     = dn;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic test_reset();
    logic [5:0] v;
    bootrom_n = 1'b0;
    dbg_n     = 3'b111;
    rst_n     = 1'b0;
    step();
    v = pmu_vec();
    n_cmp++;
    if (v !== 6'b011110) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected %b", v, 6'b011110);
    end
    n_cmp++;
    if ({c_gpa_in, c_gpb_in, c_dq_in} !== '0) begin
      n_err++; $display("FAIL reset_sync: got %h expected 0", {c_gpa_in, c_gpb_in, c_dq_in});
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({core_rst_n, padrst} !== 2'b01) begin
      n_err++; $display("FAIL release_edge1: got rst/padrst %b expected 01", {core_rst_n, padrst});
    end
    step();
    n_cmp++;
    if ({core_rst_n, padrst} !== 2'b10) begin
      n_err++; $display("FAIL release_edge2: got rst/padrst %b expected 10", {core_rst_n, padrst});
    end
    n_cmp++;
    if (core_boot_addr !== ROMB || core_dbg_mode !== 3'b000) begin
      n_err++; $display("FAIL boot_default: got %h/%b expected %h/000", core_boot_addr, core_dbg_mode, ROMB);
    end
  endtask

  task automatic test_straps();
    logic       brn;
    logic [2:0] dn;
    logic [31:0] exp_addr;
    logic [2:0]  exp_dbg;
    for (int i = 0; i < 5; i++) begin
      brn = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      dn  = (i == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      exp_addr = brn ? ITCB : ROMB;
      exp_dbg  = ~dn;
      bootrom_n = brn;
      dbg_n     = dn;
      step();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (core_boot_addr !== ROMB || core_dbg_mode !== 3'b000 || core_rst_n !== 1'b0) begin
        n_err++; $display("FAIL strap_in_reset: got %h/%b/%b expected %h/000/0", core_boot_addr, core_dbg_mode, core_rst_n, ROMB);
      end
      step();
      rst_n = 1'b1;
      step();
      step();
      n_cmp++;
      if (core_boot_addr !== exp_addr || core_dbg_mode !== exp_dbg) begin
        n_err++; $display("FAIL strap_sample: got %h/%b expected %h/%b", core_boot_addr, core_dbg_mode, exp_addr, exp_dbg);
      end
      bootrom_n = ~brn;
      dbg_n     = ~dn;
      repeat (3) step();
      n_cmp++;
      if (core_boot_addr !== exp_addr || core_dbg_mode !== exp_dbg) begin
        n_err++; $display("FAIL strap_hold: got %h/%b expected %h/%b", core_boot_addr, core_dbg_mode, exp_addr, exp_dbg);
      end
    end
  endtask

  task automatic test_sync_inputs();
    logic [2*W+3:0] q[$];
    logic [2*W+3:0] v, e;
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 2) begin
        e = q.pop_front();
        n_cmp++;
        if ({c_gpa_in, c_gpb_in, c_dq_in} !== e) begin
          n_err++; $display("FAIL sync_in[%0d]: got %h expected %h", i, {c_gpa_in, c_gpb_in, c_dq_in}, e);
        end
      end
      v = {32'($urandom), 32'($urandom), 4'($urandom)};
      if (i == 0) v[2*W+3:W+4] = 32'hA5A5_0F0F;
      {gpa_i, gpb_i, dq_i} = v;
      q.push_back(v);
      step();
    end
  endtask

  task automatic test_passthrough();
    logic [W-1:0] ao, ae, bo, be;
    logic [3:0]   qo, qe;
    logic [4:0]   m;
    for (int i = 0; i < 12; i++) begin
      ao = $urandom; ae = $urandom; bo = $urandom; be = $urandom;
      if (i == 0) begin bo = 32'h1234_5678; be = 32'hFFFF_0000; end
      qo = 4'($urandom); qe = 4'($urandom);
      m  = 5'($urandom);
      c_gpa_out = ao; c_gpa_oe = ae; c_gpb_out = bo; c_gpb_oe = be;
      c_dq_out = qo; c_dq_oe = qe;
      {c_sck, c_cs, tck, tms, tdi} = m;
      c_tdo = ~m[0]; c_tdo_oe = m[4];
      #1;
      n_cmp++;
      if ({gpa_oval, gpa_oe, gpb_oval, gpb_oe} !== {ao, ae, bo, be}) begin
        n_err++; $display("FAIL gpio_out[%0d]: got %h expected %h", i, {gpa_oval, gpa_oe, gpb_oval, gpb_oe}, {ao, ae, bo, be});
      end
      n_cmp++;
      if ({dq3_ov, dq2_ov, dq1_ov, dq0_ov, dq3_oe, dq2_oe, dq1_oe, dq0_oe, sck_oval, cs_oval} !== {qo, qe, m[4], m[3]}) begin
        n_err++; $display("FAIL qspi_out[%0d]: got %h expected %h", i,
          {dq3_ov, dq2_ov, dq1_ov, dq0_ov, dq3_oe, dq2_oe, dq1_oe, dq0_oe, sck_oval, cs_oval}, {qo, qe, m[4], m[3]});
      end
      n_cmp++;
      if ({c_tck, c_tms, c_tdi, tdo_oval, tdo_oe} !== {m[2], m[1], m[0], ~m[0], m[4]}) begin
        n_err++; $display("FAIL jtag[%0d]: got %b expected %b", i, {c_tck, c_tms, c_tdi, tdo_oval, tdo_oe}, {m[2], m[1], m[0], ~m[0], m[4]});
      end
      step();
    end
  endtask

  task automatic test_rtc();
    int n;
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? 10 : $urandom_range(3, 8);
      tick_cnt = 0;
      tick_en  = 1'b1;
      #($urandom_range(1, 5));
      for (int k = 0; k < n; k++) begin
        #33 lfextclk = 1'b1;
        #33 lfextclk = 1'b0;
      end
      repeat (8) step();
      tick_en = 1'b0;
      n_cmp++;
      if (tick_cnt != n) begin
        n_err++; $display("FAIL rtc_ticks: got %0d expected %0d", tick_cnt, n);
      end
    end
  endtask

  task automatic enter_sleep();
    c_sleep_req = 1'b1;
    step();
    c_sleep_req = 1'b0;
  endtask

  task automatic wait_wake(input string nm);
    int guard = 0;
    while (vddpaden !== 1'b1 && guard < 20) begin step(); guard++; end
    n_cmp++;
    if (vddpaden !== 1'b1) begin
      n_err++; $display("FAIL %s_wake_timeout: got vddpaden %b expected 1", nm, vddpaden);
    end
    n_cmp++;
    if ({core_rst_n, padrst} !== 2'b01) begin
      n_err++; $display("FAIL %s_wake_entry: got rst/padrst %b expected 01", nm, {core_rst_n, padrst});
    end
    step();
    n_cmp++;
    if ({core_rst_n, vddpaden} !== 2'b01) begin
      n_err++; $display("FAIL %s_wake_1: got rst/vdd %b expected 01", nm, {core_rst_n, vddpaden});
    end
    step();
    n_cmp++;
    if ({core_rst_n, padrst, vddpaden} !== 3'b101) begin
      n_err++; $display("FAIL %s_wake_2: got rst/padrst/vdd %b expected 101", nm, {core_rst_n, padrst, vddpaden});
    end
  endtask

  task automatic test_pmu();
    logic [5:0] v;
    dwakeup_n = 1'b0;
    repeat (4) step();
    n_cmp++;
    if ({core_rst_n, vddpaden, padrst} !== 3'b110) begin
      n_err++; $display("FAIL wake_in_run: got rst/vdd/padrst %b expected 110", {core_rst_n, vddpaden, padrst});
    end
    dwakeup_n = 1'b1;
    repeat (3) step();
    enter_sleep();
    v = pmu_vec();
    n_cmp++;
    if (v[5:1] !== 5'b01001) begin
      n_err++; $display("FAIL sleep_entry: got %b expected 01001", v[5:1]);
    end
    repeat ($urandom_range(3, 8)) step();
    n_cmp++;
    if ({core_rst_n, vddpaden, hfxoscen, padrst} !== 4'b0001) begin
      n_err++; $display("FAIL sleep_hold: got %b expected 0001", {core_rst_n, vddpaden, hfxoscen, padrst});
    end
    dwakeup_n = 1'b0;
    step();
    dwakeup_n = 1'b1;
    wait_wake("pulse");
    // sleep request and wake asserted together: sleep must win first
    dwakeup_n = 1'b0;
    repeat (3) step();
    enter_sleep();
    n_cmp++;
    if ({core_rst_n, vddpaden} !== 2'b00) begin
      n_err++; $display("FAIL sleep_vs_wake: got rst/vdd %b expected 00", {core_rst_n, vddpaden});
    end
    dwakeup_n = 1'b1;
    wait_wake("simul");
  endtask

  task automatic test_async_reset();
    logic [5:0] v;
    reset_release(1'b1, 3'b010);
    enter_sleep();
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    v = pmu_vec();
    n_cmp++;
    if (v !== 6'b011110 || core_boot_addr !== ROMB) begin
      n_err++; $display("FAIL async_in_sleep: got %b/%h expected 011110/%h", v, core_boot_addr, ROMB);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    repeat (3) step();
    n_cmp++;
    if ({core_rst_n, vddpaden, padrst} !== 3'b110) begin
      n_err++; $display("FAIL after_sleep_reset: got rst/vdd/padrst %b expected 110", {core_rst_n, vddpaden, padrst});
    end
    gpa_i = 32'hFFFF_FFFF;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    v = pmu_vec();
    n_cmp++;
    if (v !== 6'b011110 || c_gpa_in !== '0) begin
      n_err++; $display("FAIL async_in_run: got %b/%h expected 011110/0", v, c_gpa_in);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    n_cmp++;
    if ({core_rst_n, padrst, vddpaden} !== 3'b101) begin
      n_err++; $display("FAIL after_run_reset: got rst/padrst/vdd %b expected 101", {core_rst_n, padrst, vddpaden});
    end
  endtask

  initial begin
    test_reset();
    test_straps();
    test_sync_inputs();
    test_passthrough();
    test_rtc();
    test_pmu();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
